// File: rtl/pc_src_reg_pkg.sv
// Shared constants for the PC source selector: channel encodings, FSM state codes
// and the default datapath width.
package pc_src_reg_pkg;

    localparam int DEF_DATA_W = 32;

    localparam int PC_SRC_ALU    = 0;
    localparam int PC_SRC_INC    = 1;
    localparam int PC_SRC_ALUOUT = 2;
    localparam int PC_SRC_JUMP   = 3;
    localparam int PC_SRC_EXC    = 4;

    typedef logic [0:0] pc_state_t;

    localparam pc_state_t ST_RUN    = 1'b0;
    localparam pc_state_t ST_FROZEN = 1'b1;

endpackage

// File: rtl/pc_src_reg_mux.sv
// Combinational N-way mux over a flattened source bus; out-of-range selectors
// return channel 0 and raise oor.
module mux_n #(
    parameter int DATA_W = 32,
    parameter int N_SRC  = 5,
    parameter int SEL_W  = 3
) (
    input  logic [SEL_W-1:0]        sel,
    input  logic [N_SRC*DATA_W-1:0] data_in,
    output logic [DATA_W-1:0]       data_out,
    output logic                    oor
);

    always_comb begin
        data_out = data_in[0 +: DATA_W];
        oor      = 1'b1;
        for (int k = 0; k < N_SRC; k++) begin
            if (sel == SEL_W'(k)) begin
                data_out = data_in[k*DATA_W +: DATA_W];
                oor      = 1'b0;
            end
        end
    end

endmodule

// File: rtl/pc_src_reg.sv
// Next-PC selector and PC register with conditional load, previous-PC capture,
// misalignment rejection and a freeze-on-illegal-selector FSM.
module pc_src_reg
    import pc_src_reg_pkg::*;
#(
    parameter int                 DATA_W   = DEF_DATA_W,
    parameter int                 N_SRC    = 5,
    parameter int                 SEL_W    = 3,
    parameter int                 INC_CH   = PC_SRC_INC,
    parameter int                 INC      = 4,
    parameter logic [DATA_W-1:0]  RESET_PC = '0,
    parameter int                 ALIGN_B  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SEL_W-1:0]        selector,
    input  logic [N_SRC*DATA_W-1:0] data_in,
    input  logic                    pc_wr,
    input  logic                    pc_wr_cond,
    input  logic                    cond,
    input  logic                    err_clr,
    output logic [DATA_W-1:0]       pc_out,
    output logic [DATA_W-1:0]       pc_prev,
    output logic                    sel_err,
    output logic                    align_err
);

    // A zero mask (ALIGN_B == 0) disables the alignment check naturally.
    localparam logic [DATA_W-1:0] ALIGN_MASK = DATA_W'((64'd1 << ALIGN_B) - 64'd1);

    pc_state_t         state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              sel_err_q, sel_err_d;
    logic              align_err_q, align_err_d;

    logic [DATA_W-1:0] mux_out;
    logic              sel_illegal;
    logic [DATA_W-1:0] nxt;
    logic              ld;
    logic              misaligned;

    mux_n #(
        .DATA_W (DATA_W),
        .N_SRC  (N_SRC),
        .SEL_W  (SEL_W)
    ) u_mux (
        .sel      (selector),
        .data_in  (data_in),
        .data_out (mux_out),
        .oor      (sel_illegal)
    );

    assign nxt        = (selector == SEL_W'(INC_CH)) ? pc_q + DATA_W'(INC) : mux_out;
    assign ld         = pc_wr | (pc_wr_cond & cond);
    assign misaligned = (nxt & ALIGN_MASK) != '0;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        prev_d      = prev_q;
        sel_err_d   = sel_err_q;
        align_err_d = 1'b0;
        if (state_q == ST_RUN) begin
            if (err_clr) sel_err_d = 1'b0;
            if (ld) begin
                if (sel_illegal) begin
                    sel_err_d = 1'b1;
                    state_d   = ST_FROZEN;
                end else if (misaligned) begin
                    align_err_d = 1'b1;
                end else begin
                    prev_d = pc_q;
                    pc_d   = nxt;
                end
            end
        end else if (err_clr) begin
            // Any load presented alongside the clear is dropped.
            sel_err_d = 1'b0;
            state_d   = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            prev_q      <= '0;
            sel_err_q   <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            prev_q      <= prev_d;
            sel_err_q   <= sel_err_d;
            align_err_q <= align_err_d;
        end
    end

    assign pc_out    = pc_q;
    assign pc_prev   = prev_q;
    assign sel_err   = sel_err_q;
    assign align_err = align_err_q;

endmodule
